sevenseg_scan_ctrl: RTL and testbench

SEVENSEG_SCAN_CTRL -- requirements
Module: sevenseg_scan_ctrl

---
 rtl/sevenseg_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with frame-synchronous display update.
// Writes are held pending and only reach the displayed shadow copy at the end of digit 7's slot.
module sevenseg_scan_ctrl #(
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_wr_en,
   input  logic [31:0] i_wr_data,
   input  logic [7:0]  i_wr_mask,
   output logic [7:0]  o_an,
   output logic [6:0]  o_seg,
   output logic        o_frame_done,
   output logic        o_update_pending
);

   localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

   logic [CW-1:0] cnt_r;
   logic [2:0]    idx_r;
   logic [31:0]   pend_data_r;
   logic [31:0]   shad_data_r;
   logic [7:0]    pend_mask_r;
   logic [7:0]    shad_mask_r;
   logic          pend_r;
   logic          frame_done_r;
   logic [7:0]    an_r;
   logic [6:0]    seg_r;

   logic          terminal_s;
   logic          boundary_s;
   logic          active_s;
   logic [3:0]    nib_s;
   logic [7:0]    an_s;
   logic [6:0]    seg_s;

   // Segment order CA..CG from MSB to LSB, active-low.
   function automatic logic [6:0] hex_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b0000001;
         4'h1:    seg = 7'b1001111;
         4'h2:    seg = 7'b0010010;
         4'h3:    seg = 7'b0000110;
         4'h4:    seg = 7'b1001100;
         4'h5:    seg = 7'b0100100;
         4'h6:    seg = 7'b0100000;
         4'h7:    seg = 7'b0001111;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0000100;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b1100000;
         4'hC:    seg = 7'b0110001;
         4'hD:    seg = 7'b1000010;
         4'hE:    seg = 7'b0110000;
         4'hF:    seg = 7'b0111000;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   // Slot decode and next-cycle anode/segment values from the shadow copy.
   always_comb begin
      terminal_s = (cnt_r == CW'(DIGIT_CYCLES - 1));
      boundary_s = terminal_s && (idx_r == 3'd7);
      nib_s      = shad_data_r[{idx_r, 2'b00} +: 4];
      active_s   = (cnt_r >= CW'(BLANK_CYCLES)) && shad_mask_r[idx_r];
      an_s       = 8'hFF;
      seg_s      = 7'h7F;
      if (active_s) begin
         an_s  = ~(8'd1 << idx_r);
         seg_s = hex_decode(nib_s);
      end else begin
         an_s  = 8'hFF;
         seg_s = 7'h7F;
      end
   end

   // Prescaler and digit index.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_r <= '0;
         idx_r <= 3'd0;
      end else if (terminal_s) begin
         cnt_r <= '0;
         idx_r <= idx_r + 3'd1;
      end else begin
         cnt_r <= cnt_r + CW'(1);
      end
   end

   // Pending/shadow registers; a write landing on the boundary bypasses pending.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend_data_r  <= 32'd0;
         pend_mask_r  <= 8'd0;
         shad_data_r  <= 32'd0;
         shad_mask_r  <= 8'd0;
         pend_r       <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         if (i_wr_en) begin
            pend_data_r <= i_wr_data;
            pend_mask_r <= i_wr_mask;
         end
         if (boundary_s) begin
            if (i_wr_en) begin
               shad_data_r <= i_wr_data;
               shad_mask_r <= i_wr_mask;
            end else if (pend_r) begin
               shad_data_r <= pend_data_r;
               shad_mask_r <= pend_mask_r;
            end
            pend_r <= 1'b0;
         end else if (i_wr_en) begin
            pend_r <= 1'b1;
         end
         frame_done_r <= boundary_s;
      end
   end

   // Registered display outputs, one cycle behind the scan state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         an_r  <= 8'hFF;
         seg_r <= 7'h7F;
      end else begin
         an_r  <= an_s;
         seg_r <= seg_s;
      end
   end

   assign o_an             = an_r;
   assign o_seg            = seg_r;
   assign o_frame_done     = frame_done_r;
   assign o_update_pending = pend_r;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with DIGIT_CYCLES=8, BLANK_CYCLES=2.
// A frame is 64 cycles; sampling happens on the falling clock edge.
module tb_sevenseg_scan_ctrl;

   localparam int DC = 8;
   localparam int BC = 2;

   logic        clk;
   logic        rstn;
   logic        i_wr_en;
   logic [31:0] i_wr_data;
   logic [7:0]  i_wr_mask;
   logic [7:0]  o_an;
   logic [6:0]  o_seg;
   logic        o_frame_done;
   logic        o_update_pending;

   sevenseg_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
      .clk              (clk),
      .rstn             (rstn),
      .i_wr_en          (i_wr_en),
      .i_wr_data        (i_wr_data),
      .i_wr_mask        (i_wr_mask),
      .o_an             (o_an),
      .o_seg            (o_seg),
      .o_frame_done     (o_frame_done),
      .o_update_pending (o_update_pending)
   );

   typedef struct {
      logic [3:0] nib;
      logic [6:0] seg;
   } dec_vec_t;

   typedef struct {
      logic [31:0] data;   // shadow contents displayed during this frame
      logic [7:0]  mask;
      int          wr_at;  // scan position of the write, -1 for none
      logic [31:0] d1;
      logic [7:0]  m1;
      bit          dbl;    // second write on the following cycle
      logic [31:0] d2;
      logic [7:0]  m2;
   } scene_t;

   dec_vec_t dec_tab [16];
   scene_t   scenes  [6];
   int       n_cmp = 0;
   int       n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic idle_check(input int n);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         chk("idle_an", 32'(o_an), 32'h0000_00FF);
         chk("idle_seg", 32'(o_seg), 32'h0000_007F);
         chk("idle_frame_done", 32'(o_frame_done), 32'((k % 64) == 0));
         chk("idle_pending", 32'(o_update_pending), 32'h0);
      end
   endtask

   task automatic wait_fd();
      int t;
      t = 0;
      while (o_frame_done !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("frame_done_wait", 32'(o_frame_done), 32'h1);
   endtask

   // Entered on the falling edge where o_frame_done is high (scan at digit 0, count 0).
   task automatic run_frame(input scene_t s);
      int         slot;
      int         c;
      logic [3:0] nib;
      logic [7:0] exp_an;
      logic [6:0] exp_seg;
      bit         exp_pend;
      for (int k = 1; k <= 64; k++) begin
         slot = (k - 1) / DC;
         c    = (k - 1) % DC;
         if (s.wr_at >= 0 && k - 1 == s.wr_at) begin
            i_wr_en   = 1'b1;
            i_wr_data = s.d1;
            i_wr_mask = s.m1;
         end else if (s.dbl && s.wr_at >= 0 && k - 1 == s.wr_at + 1) begin
            i_wr_en   = 1'b1;
            i_wr_data = s.d2;
            i_wr_mask = s.m2;
         end else begin
            i_wr_en = 1'b0;
         end
         @(negedge clk);
         nib = s.data[4*slot +: 4];
         if (c < BC || !s.mask[slot]) begin
            exp_an  = 8'hFF;
            exp_seg = 7'h7F;
         end else begin
            exp_an  = ~(8'd1 << slot);
            exp_seg = dec_tab[nib].seg;
         end
         exp_pend = (s.wr_at >= 0) && (k - 1 >= s.wr_at) && (k != 64);
         chk("an", 32'(o_an), 32'(exp_an));
         chk("seg", 32'(o_seg), 32'(exp_seg));
         chk("frame_done", 32'(o_frame_done), 32'(k == 64));
         chk("pending", 32'(o_update_pending), 32'(exp_pend));
      end
      i_wr_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      dec_tab[0]  = '{nib: 4'h0, seg: 7'b0000001};
      dec_tab[1]  = '{nib: 4'h1, seg: 7'b1001111};
      dec_tab[2]  = '{nib: 4'h2, seg: 7'b0010010};
      dec_tab[3]  = '{nib: 4'h3, seg: 7'b0000110};
      dec_tab[4]  = '{nib: 4'h4, seg: 7'b1001100};
      dec_tab[5]  = '{nib: 4'h5, seg: 7'b0100100};
      dec_tab[6]  = '{nib: 4'h6, seg: 7'b0100000};
      dec_tab[7]  = '{nib: 4'h7, seg: 7'b0001111};
      dec_tab[8]  = '{nib: 4'h8, seg: 7'b0000000};
      dec_tab[9]  = '{nib: 4'h9, seg: 7'b0000100};
      dec_tab[10] = '{nib: 4'hA, seg: 7'b0001000};
      dec_tab[11] = '{nib: 4'hB, seg: 7'b1100000};
      dec_tab[12] = '{nib: 4'hC, seg: 7'b0110001};
      dec_tab[13] = '{nib: 4'hD, seg: 7'b1000010};
      dec_tab[14] = '{nib: 4'hE, seg: 7'b0110000};
      dec_tab[15] = '{nib: 4'hF, seg: 7'b0111000};

      scenes[0] = '{32'h7654_3210, 8'hFF, -1, 32'h0, 8'h00, 1'b0, 32'h0, 8'h00};
      scenes[1] = '{32'h7654_3210, 8'hFF, 20, 32'hFFFF_FFFF, 8'hFF, 1'b0, 32'h0, 8'h00};
      scenes[2] = '{32'hFFFF_FFFF, 8'hFF, 63, 32'hFEDC_BA98, 8'hFF, 1'b0, 32'h0, 8'h00};
      scenes[3] = '{32'hFEDC_BA98, 8'hFF, 63, 32'h0000_00A0, 8'h05, 1'b0, 32'h0, 8'h00};
      scenes[4] = '{32'h0000_00A0, 8'h05, 10, 32'h1111_1111, 8'hFF, 1'b1, 32'h9876_5432, 8'hF8};
      scenes[5] = '{32'h9876_5432, 8'hF8, -1, 32'h0, 8'h00, 1'b0, 32'h0, 8'h00};

      rstn      = 1'b0;
      i_wr_en   = 1'b0;
      i_wr_data = 32'h0;
      i_wr_mask = 8'h0;
      repeat (3) @(negedge clk);
      chk("rst_an", 32'(o_an), 32'h0000_00FF);
      chk("rst_seg", 32'(o_seg), 32'h0000_007F);
      chk("rst_frame_done", 32'(o_frame_done), 32'h0);
      chk("rst_pending", 32'(o_update_pending), 32'h0);
      rstn = 1'b1;

      idle_check(200);

      // Mid-frame write: pending rises, display stays dark until the boundary.
      i_wr_en   = 1'b1;
      i_wr_data = 32'h7654_3210;
      i_wr_mask = 8'hFF;
      @(negedge clk);
      i_wr_en = 1'b0;
      chk("first_wr_pending", 32'(o_update_pending), 32'h1);
      chk("first_wr_an", 32'(o_an), 32'h0000_00FF);
      wait_fd();
      chk("first_wr_pending_clr", 32'(o_update_pending), 32'h0);

      for (int i = 0; i < 6; i++) run_frame(scenes[i]);

      // Reset at count 5 of slot 3 with a write pending.
      i_wr_en   = 1'b1;
      i_wr_data = 32'h5555_5555;
      i_wr_mask = 8'hFF;
      @(negedge clk);
      i_wr_en = 1'b0;
      repeat (28) @(negedge clk);
      chk("pre_rst_pending", 32'(o_update_pending), 32'h1);
      chk("pre_rst_an", 32'(o_an), 32'h0000_00F7);
      chk("pre_rst_seg", 32'(o_seg), 32'h0000_0024);
      rstn = 1'b0;
      #1;
      chk("async_rst_an", 32'(o_an), 32'h0000_00FF);
      chk("async_rst_seg", 32'(o_seg), 32'h0000_007F);
      chk("async_rst_pending", 32'(o_update_pending), 32'h0);
      chk("async_rst_frame_done", 32'(o_frame_done), 32'h0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      idle_check(200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
